// File: rtl/qm_memarb_pkg.sv
// rtl/qm_memarb_pkg.sv - shared line geometry and grant-side encoding for the memory arbiter
package qm_memarb_pkg;

  localparam int QM_LINE_WORDS = 4;
  localparam int QM_LW_BITS    = 2;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/qm_memarb_if.sv
// rtl/qm_memarb_if.sv - I-side, D-side and backing-memory signals of the memory arbiter
interface qm_memarb_if
  import qm_memarb_pkg::*;
#(
  parameter int LW_BITS = QM_LW_BITS
) ();

  logic               ic_req;
  logic [31:0]        ic_address;
  logic               ic_valid;
  logic [LW_BITS-1:0] ic_word;
  logic [31:0]        ic_data;
  logic               ic_done;

  logic               dm_req;
  logic               dm_write;
  logic [31:0]        dm_address;
  logic [31:0]        dm_wdata;
  logic               dm_ack;
  logic [31:0]        dm_rdata;

  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               mem_ack;

  modport slave (
    input  ic_req, ic_address, dm_req, dm_write, dm_address, dm_wdata, mem_rdata, mem_ack,
    output ic_valid, ic_word, ic_data, ic_done, dm_ack, dm_rdata,
           mem_address, mem_read, mem_write, mem_wdata
  );

  modport master (
    output ic_req, ic_address, dm_req, dm_write, dm_address, dm_wdata, mem_rdata, mem_ack,
    input  ic_valid, ic_word, ic_data, ic_done, dm_ack, dm_rdata,
           mem_address, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/qm_memarb.sv
// rtl/qm_memarb.sv - round-robin arbiter sharing one memory port between I-line fills and D accesses
module qm_memarb
  import qm_memarb_pkg::*;
#(
  parameter int LINE_WORDS = QM_LINE_WORDS,
  parameter int LW_BITS    = QM_LW_BITS
) (
  input  logic        sys_clk,
  input  logic        reset,
  qm_memarb_if.slave  bus
);

  localparam int                 BASE_W    = 30 - LW_BITS;
  localparam logic [LW_BITS-1:0] LAST_WORD = LW_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IFILL = 2'd1,
    S_DACC  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  grant_e              last_grant_q, last_grant_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [LW_BITS-1:0]  cnt_q, cnt_d;
  logic                d_write_q, d_write_d;

  logic [31:0]         mem_address_q, mem_address_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                ic_valid_q, ic_valid_d;
  logic [LW_BITS-1:0]  ic_word_q, ic_word_d;
  logic [31:0]         ic_data_q, ic_data_d;
  logic                ic_done_q, ic_done_d;
  logic                dm_ack_q, dm_ack_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;

  logic                ic_elig, dm_elig;
  logic [LW_BITS-1:0]  cnt_inc;
  logic                unused_addr_bits;

  // A requester still sees its own completion pulse this cycle, so it is not yet eligible.
  assign ic_elig          = bus.ic_req && !ic_done_q;
  assign dm_elig          = bus.dm_req && !dm_ack_q;
  assign cnt_inc          = cnt_q + 1'b1;
  assign unused_addr_bits = ^bus.ic_address[LW_BITS+1:0];

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    d_write_d     = d_write_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_wdata_d   = mem_wdata_q;
    ic_valid_d    = 1'b0;
    ic_word_d     = ic_word_q;
    ic_data_d     = ic_data_q;
    ic_done_d     = 1'b0;
    dm_ack_d      = 1'b0;
    dm_rdata_d    = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (ic_elig && (!dm_elig || last_grant_q == GRANT_D)) begin
          state_d       = S_IFILL;
          last_grant_d  = GRANT_I;
          base_d        = bus.ic_address[31:LW_BITS+2];
          cnt_d         = '0;
          mem_address_d = {bus.ic_address[31:LW_BITS+2], {LW_BITS{1'b0}}, 2'b00};
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
        end else if (dm_elig) begin
          state_d       = S_DACC;
          last_grant_d  = GRANT_D;
          d_write_d     = bus.dm_write;
          mem_address_d = bus.dm_address;
          mem_wdata_d   = bus.dm_wdata;
          mem_write_d   = bus.dm_write;
          mem_read_d    = !bus.dm_write;
        end
      end

      S_IFILL: begin
        if (bus.mem_ack) begin
          ic_valid_d = 1'b1;
          ic_word_d  = cnt_q;
          ic_data_d  = bus.mem_rdata;
          if (cnt_q == LAST_WORD) begin
            ic_done_d  = 1'b1;
            mem_read_d = 1'b0;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            cnt_d         = cnt_inc;
            mem_address_d = {base_q, cnt_inc, 2'b00};
          end
        end
      end

      S_DACC: begin
        if (bus.mem_ack) begin
          dm_ack_d    = 1'b1;
          if (!d_write_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight command at once; the memory side tolerates the abandoned request.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_D;
      base_q        <= '0;
      cnt_q         <= '0;
      d_write_q     <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
      ic_valid_q    <= 1'b0;
      ic_word_q     <= '0;
      ic_data_q     <= '0;
      ic_done_q     <= 1'b0;
      dm_ack_q      <= 1'b0;
      dm_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      d_write_q     <= d_write_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
      ic_valid_q    <= ic_valid_d;
      ic_word_q     <= ic_word_d;
      ic_data_q     <= ic_data_d;
      ic_done_q     <= ic_done_d;
      dm_ack_q      <= dm_ack_d;
      dm_rdata_q    <= dm_rdata_d;
    end
  end

  assign bus.mem_address = mem_address_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.ic_valid    = ic_valid_q;
  assign bus.ic_word     = ic_word_q;
  assign bus.ic_data     = ic_data_q;
  assign bus.ic_done     = ic_done_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.dm_rdata    = dm_rdata_q;

endmodule

// File: tb/tb_qm_memarb.sv
// tb/tb_qm_memarb.sv - directed bench for qm_memarb with a wait-state programmable memory responder
module tb_qm_memarb;
  import qm_memarb_pkg::*;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  qm_memarb_if bus ();

  qm_memarb dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int ws     = 0;
  int wcnt   = 0;
  int nvalid = 0;
  logic [31:0] store [logic [31:0]];

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_read"},    32'(bus.mem_read),  32'd0);
    check({tag, "_mem_write"},   32'(bus.mem_write), 32'd0);
    check({tag, "_mem_address"}, bus.mem_address,    32'd0);
    check({tag, "_mem_wdata"},   bus.mem_wdata,      32'd0);
    check({tag, "_ic_valid"},    32'(bus.ic_valid),  32'd0);
    check({tag, "_ic_word"},     32'(bus.ic_word),   32'd0);
    check({tag, "_ic_data"},     bus.ic_data,        32'd0);
    check({tag, "_ic_done"},     32'(bus.ic_done),   32'd0);
    check({tag, "_dm_ack"},      32'(bus.dm_ack),    32'd0);
    check({tag, "_dm_rdata"},    bus.dm_rdata,       32'd0);
  endtask

  task automatic wait_ic_done(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (bus.ic_done) seen = 1'b1;
    end
    check({tag, "_ic_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_dm_ack(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (bus.dm_ack) seen = 1'b1;
    end
    check({tag, "_dm_ack_seen"}, 32'(seen), 32'd1);
  endtask

  // Memory model: acks a command after ws idle cycles; write data is remembered for later reads.
  always @(negedge sys_clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (wcnt < ws) begin
        wcnt        = wcnt + 1;
        bus.mem_ack = 1'b0;
      end else begin
        wcnt        = 0;
        bus.mem_ack = 1'b1;
        if (bus.mem_write) store[bus.mem_address] = bus.mem_wdata;
        bus.mem_rdata = store.exists(bus.mem_address) ? store[bus.mem_address]
                                                      : rd_pat(bus.mem_address);
      end
    end else begin
      wcnt        = 0;
      bus.mem_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    bus.ic_req     = 1'b0;
    bus.ic_address = '0;
    bus.dm_req     = 1'b0;
    bus.dm_write   = 1'b0;
    bus.dm_address = '0;
    bus.dm_wdata   = '0;
    bus.mem_rdata  = '0;
    bus.mem_ack    = 1'b0;

    reset = 1'b1;
    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;
    step();
    check("idle_no_cmd", 32'(bus.mem_read), 32'd0);

    // Lone I-fill, zero-wait memory
    bus.ic_address = 32'h0000_1234;
    bus.ic_req     = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      check("fill_addr",  bus.mem_address, 32'h0000_1230 + 32'(4 * k));
      check("fill_read",  32'(bus.mem_read),  32'd1);
      check("fill_write", 32'(bus.mem_write), 32'd0);
      step();
      check("fill_valid", 32'(bus.ic_valid), 32'd1);
      check("fill_word",  32'(bus.ic_word),  32'(k));
      check("fill_data",  bus.ic_data, rd_pat(32'h0000_1230 + 32'(4 * k)));
      check("fill_done",  32'(bus.ic_done), (k == 3) ? 32'd1 : 32'd0);
    end
    check("fill_end_read", 32'(bus.mem_read), 32'd0);
    step();
    check("fill_no_regrant", 32'(bus.mem_read), 32'd0);
    check("fill_valid_off",  32'(bus.ic_valid), 32'd0);
    bus.ic_req = 1'b0;
    step();

    // Lone D-write then D-read at 0x80
    bus.dm_address = 32'h0000_0080;
    bus.dm_wdata   = 32'hDEAD_BEEF;
    bus.dm_write   = 1'b1;
    bus.dm_req     = 1'b1;
    step();
    check("dw_write",   32'(bus.mem_write), 32'd1);
    check("dw_read",    32'(bus.mem_read),  32'd0);
    check("dw_addr",    bus.mem_address, 32'h0000_0080);
    check("dw_wdata",   bus.mem_wdata,   32'hDEAD_BEEF);
    step();
    check("dw_ack",     32'(bus.dm_ack),    32'd1);
    check("dw_cmd_off", 32'(bus.mem_write), 32'd0);
    bus.dm_req = 1'b0;
    step();
    bus.dm_write = 1'b0;
    bus.dm_req   = 1'b1;
    step();
    check("dr_read",  32'(bus.mem_read),  32'd1);
    check("dr_write", 32'(bus.mem_write), 32'd0);
    check("dr_addr",  bus.mem_address, 32'h0000_0080);
    step();
    check("dr_ack",   32'(bus.dm_ack), 32'd1);
    check("dr_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
    bus.dm_req = 1'b0;
    step();

    // First tie after reset goes to I; D wins once I is masked by its own ic_done
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.ic_address = 32'h0000_2000;
    bus.ic_req     = 1'b1;
    bus.dm_address = 32'h0000_0100;
    bus.dm_write   = 1'b0;
    bus.dm_req     = 1'b1;
    step();
    check("tie1_i_addr", bus.mem_address, 32'h0000_2000);
    check("tie1_i_read", 32'(bus.mem_read), 32'd1);
    wait_ic_done("tie1", 20);
    step();
    check("tie1_d_addr", bus.mem_address, 32'h0000_0100);
    check("tie1_d_read", 32'(bus.mem_read), 32'd1);
    bus.ic_req = 1'b0;
    wait_dm_ack("tie1", 10);
    check("tie1_d_rdata", bus.dm_rdata, rd_pat(32'h0000_0100));
    bus.dm_req = 1'b0;
    step();

    // Lone I grant, then a fresh tie goes to D first and I afterwards
    bus.ic_address = 32'h0000_2040;
    bus.ic_req     = 1'b1;
    wait_ic_done("lone_i", 20);
    step();
    bus.ic_req = 1'b0;
    check("lone_i_no_regrant", 32'(bus.mem_read), 32'd0);
    bus.ic_address = 32'h0000_2080;
    bus.ic_req     = 1'b1;
    bus.dm_address = 32'h0000_0104;
    bus.dm_req     = 1'b1;
    step();
    check("tie2_d_addr", bus.mem_address, 32'h0000_0104);
    wait_dm_ack("tie2", 10);
    step();
    check("tie2_i_addr", bus.mem_address, 32'h0000_2080);
    check("tie2_i_read", 32'(bus.mem_read), 32'd1);
    bus.dm_req = 1'b0;
    wait_ic_done("tie2", 20);
    step();
    bus.ic_req = 1'b0;
    step();

    // Two wait states per word; a pending D write must not interrupt the fill
    ws = 2;
    bus.ic_address = 32'h0000_4000;
    bus.ic_req     = 1'b1;
    step();
    bus.dm_address = 32'h0000_0200;
    bus.dm_wdata   = 32'h1111_2222;
    bus.dm_write   = 1'b1;
    bus.dm_req     = 1'b1;
    nvalid = 0;
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 3; c++) begin
        check("ws_addr",    bus.mem_address, 32'h0000_4000 + 32'(4 * w));
        check("ws_nowrite", 32'(bus.mem_write), 32'd0);
        step();
        if (bus.ic_valid) nvalid++;
      end
    end
    check("ws_valid_count", 32'(nvalid), 32'd4);
    check("ws_done",        32'(bus.ic_done), 32'd1);
    step();
    bus.ic_req = 1'b0;
    check("ws_d_write", 32'(bus.mem_write), 32'd1);
    check("ws_d_addr",  bus.mem_address, 32'h0000_0200);
    wait_dm_ack("ws", 10);
    bus.dm_req = 1'b0;
    ws = 0;
    step();

    // Reset during the second word of a fill, then restart from word 0
    bus.ic_address = 32'h0000_3000;
    bus.ic_req     = 1'b1;
    step();
    check("rst_w0_addr", bus.mem_address, 32'h0000_3000);
    step();
    check("rst_w1_addr", bus.mem_address, 32'h0000_3004);
    reset = 1'b1;
    step();
    check_zero("rst_mid");
    reset = 1'b0;
    step();
    check("rst_restart_addr", bus.mem_address, 32'h0000_3000);
    check("rst_restart_read", 32'(bus.mem_read), 32'd1);
    step();
    check("rst_restart_word", 32'(bus.ic_word), 32'd0);
    wait_ic_done("rst", 20);
    check("rst_last_word", 32'(bus.ic_word), 32'd3);
    check("rst_last_data", bus.ic_data, rd_pat(32'h0000_300C));
    step();
    bus.ic_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
